seq_detector_prog: RTL

//  Programmable serial pattern detector, the parametrised successor of the fixed "101100" detector.
//  - Pattern length is a parameter; pattern and per-bit don't-care mask are loadable at run time.
//  - Overlapping / non-overlapping match mode; per-bit valid qualifier; saturating match counter.
//  - Sits after the bit-serial input stage; drives a one-cycle match pulse plus a match count to status logic.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_detector_prog_if.sv | 29 ++
 rtl/seq_detector_prog_sat_counter.sv | 23 ++
 rtl/seq_detector_prog.sv | 83 ++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
// No logic: constants and one elaboration-time helper.
package seq_det_pkg;

  localparam int SEQ_DET_NMAX = 32;
  localparam logic [5:0] SEQ_PAT_DEF = 6'b101100;

  // Bits needed to hold a fill count of 0..n inclusive.
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Serial-in / status-out bundle of the programmable pattern detector.
// master drives the bit stream and configuration; slave is the detector.
interface seq_detector_prog_if #(
  parameter int N     = 6,
  parameter int CNT_W = 8
);

  logic             seq_valid;
  logic             seq;
  logic             cfg_load;
  logic [N-1:0]     cfg_pattern;
  logic [N-1:0]     cfg_mask;
  logic             overlap;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output seq_valid, seq, cfg_load, cfg_pattern, cfg_mask, overlap, cnt_clr,
    input  match, match_cnt, armed
  );

  modport slave (
    input  seq_valid, seq, cfg_load, cfg_pattern, cfg_mask, overlap, cnt_clr,
    output match, match_cnt, armed
  );

endinterface

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with clear taking priority over increment.
// Count updates on the edge after inc/clr; no backpressure.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with don't-care mask and overlap control.
// match pulses one cycle after the final bit's edge; bits are taken only when seq_valid=1.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int           N           = 6,
  parameter logic [N-1:0] DEF_PATTERN = N'(SEQ_PAT_DEF),
  parameter logic [N-1:0] DEF_MASK    = {N{1'b1}},
  parameter int           CNT_W       = 8
) (
  input logic                clk,
  input logic                rst,
  seq_detector_prog_if.slave bus
);

  localparam int FW = fill_w(N);

  logic [N-1:0]  hist, hist_d;
  logic [FW-1:0] fill, fill_d;
  logic [N-1:0]  pattern, pattern_d;
  logic [N-1:0]  mask, mask_d;
  logic [N-1:0]  cand;
  logic          hit;
  logic          match_q;
  logic          armed_q;

  // The candidate already includes the bit arriving on this edge.
  assign cand = {hist[N-2:0], bus.seq};
  assign hit  = bus.seq_valid && !bus.cfg_load && (fill >= FW'(N - 1)) &&
                (((cand ^ pattern) & mask) == '0);

  always_comb begin
    hist_d    = hist;
    fill_d    = fill;
    pattern_d = pattern;
    mask_d    = mask;
    if (bus.cfg_load) begin
      pattern_d = bus.cfg_pattern;
      mask_d    = bus.cfg_mask;
      hist_d    = '0;
      fill_d    = '0;
    end else if (bus.seq_valid) begin
      hist_d = cand;
      if (hit && !bus.overlap) begin
        fill_d = '0;
      end else if (fill != FW'(N)) begin
        fill_d = fill + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= DEF_PATTERN;
      mask    <= DEF_MASK;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist    <= hist_d;
      fill    <= fill_d;
      pattern <= pattern_d;
      mask    <= mask_d;
      match_q <= hit;
      armed_q <= (fill_d >= FW'(N));
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (bus.cnt_clr),
    .cnt (bus.match_cnt)
  );

  assign bus.match = match_q;
  assign bus.armed = armed_q;

endmodule
